// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_boot_loader
//  Description : Receives a framed program image from a UART byte stream and
//                writes it word-by-word over a simple request/ack bus. Holds
//                the core in reset until a frame with a good checksum loads.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_boot_loader #(
   parameter logic [7:0]  MAGIC          = 8'hB0,
   parameter int          TIMEOUT_CYCLES = 1_000_000,
   parameter logic [15:0] MAX_WORDS      = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        m_req,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_ack,
   output logic        core_rst_b,
   output logic        busy,
   output logic        err,
   output logic [15:0] words_written
);

   localparam int               c_TW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_TW-1:0]  c_TMO = c_TW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_COUNT = 3'd2,
      S_DATA  = 3'd3,
      S_WRITE = 3'd4,
      S_CSUM  = 3'd5,
      S_DONE  = 3'd6,
      S_ERR   = 3'd7
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_idx;
   logic [15:0]       r_count;
   logic [7:0]        r_csum;
   logic [c_TW-1:0]   r_tmo;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic              r_core_rst_b;
   logic              r_busy;
   logic              r_err;
   logic [15:0]       r_words;

   logic              w_acc;
   logic              w_timed;
   logic              w_tmo_hit;
   logic [15:0]       w_cnt_full;
   logic [15:0]       w_words_inc;

   // Handshake and bus request depend only on state, so reset drops m_req at once
   assign rx_ready      = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_COUNT) ||
                          (r_state == S_DATA) || (r_state == S_CSUM);
   assign m_req         = (r_state == S_WRITE);
   assign w_acc         = rx_valid & rx_ready;
   assign w_timed       = (r_state == S_ADDR) || (r_state == S_COUNT) ||
                          (r_state == S_DATA) || (r_state == S_CSUM);
   assign w_tmo_hit     = w_timed && (r_tmo == c_TMO);
   assign w_cnt_full    = {rx_data, r_count[7:0]};
   assign w_words_inc   = r_words + 16'd1;

   assign m_addr        = r_addr;
   assign m_wdata       = r_wdata;
   assign core_rst_b    = r_core_rst_b;
   assign busy          = r_busy;
   assign err           = r_err;
   assign words_written = r_words;

   // State register
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state decode; an expired idle timer overrides any byte activity
   always_comb begin
      w_state_nxt = r_state;
      if (w_tmo_hit) begin
         w_state_nxt = S_ERR;
      end else begin
         case (r_state)
            S_IDLE:  if (w_acc && (rx_data == MAGIC)) w_state_nxt = S_ADDR;
            S_ADDR:  if (w_acc && (r_idx == 2'd3))
                        w_state_nxt = (r_addr[1:0] != 2'b00) ? S_ERR : S_COUNT;
            S_COUNT: if (w_acc && (r_idx == 2'd1)) begin
                        if (w_cnt_full > MAX_WORDS)   w_state_nxt = S_ERR;
                        else if (w_cnt_full == 16'd0) w_state_nxt = S_CSUM;
                        else                          w_state_nxt = S_DATA;
                     end
            S_DATA:  if (w_acc && (r_idx == 2'd3)) w_state_nxt = S_WRITE;
            S_WRITE: if (m_ack) w_state_nxt = (w_words_inc == r_count) ? S_CSUM : S_DATA;
            S_CSUM:  if (w_acc) w_state_nxt = (rx_data == r_csum) ? S_DONE : S_ERR;
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Idle-byte timer: cleared on every accepted byte and outside byte-collecting states
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)                 r_tmo <= '0;
      else if (!w_timed || w_acc) r_tmo <= '0;
      else if (!w_tmo_hit)        r_tmo <= r_tmo + 1'b1;
   end

   // Frame datapath: field assembly, checksum, write bookkeeping and status flags
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_idx        <= 2'd0;
         r_count      <= 16'd0;
         r_csum       <= 8'd0;
         r_addr       <= 32'd0;
         r_wdata      <= 32'd0;
         r_core_rst_b <= 1'b0;
         r_busy       <= 1'b0;
         r_err        <= 1'b0;
         r_words      <= 16'd0;
      end else begin
         case (r_state)
            S_IDLE: if (w_acc && (rx_data == MAGIC)) begin
               r_busy       <= 1'b1;
               r_err        <= 1'b0;
               r_core_rst_b <= 1'b0;
               r_csum       <= 8'd0;
               r_words      <= 16'd0;
               r_idx        <= 2'd0;
            end
            S_ADDR: if (w_acc) begin
               r_addr[{r_idx, 3'b000} +: 8] <= rx_data;
               r_csum <= r_csum + rx_data;
               r_idx  <= r_idx + 2'd1;
            end
            S_COUNT: if (w_acc) begin
               r_count[{r_idx[0], 3'b000} +: 8] <= rx_data;
               r_csum <= r_csum + rx_data;
               // Two count bytes only; restart the index for the data words
               r_idx  <= (r_idx == 2'd1) ? 2'd0 : r_idx + 2'd1;
            end
            S_DATA: if (w_acc) begin
               r_wdata[{r_idx, 3'b000} +: 8] <= rx_data;
               r_csum <= r_csum + rx_data;
               r_idx  <= r_idx + 2'd1;
            end
            S_WRITE: if (m_ack) begin
               r_addr  <= r_addr + 32'd4;
               r_words <= w_words_inc;
            end
            S_DONE: begin
               r_core_rst_b <= 1'b1;
               r_busy       <= 1'b0;
            end
            S_ERR: begin
               r_err  <= 1'b1;
               r_busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_boot_loader
//  Description : Directed self-checking bench for uart_boot_loader with a
//                bus slave model that records writes and programmable ack delay.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_boot_loader;

   localparam int TMO = 40;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        m_req;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_ack = 1'b0;
   logic        core_rst_b;
   logic        busy;
   logic        err;
   logic [15:0] words_written;

   int n_err = 0;
   int n_chk = 0;

   // Slave model state
   int          ack_delay = 0;
   int          hold = 0;
   bit          unstable = 1'b0;
   logic [31:0] h_addr, h_data;
   logic [31:0] wr_addr [8];
   logic [31:0] wr_data [8];
   int          wr_hold [8];
   int          wr_n = 0;

   always #5 clk = ~clk;

   uart_boot_loader #(
      .MAGIC          (8'hB0),
      .TIMEOUT_CYCLES (TMO),
      .MAX_WORDS      (16'hFFFF)
   ) dut (
      .clk           (clk),
      .rst_b         (rst_b),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .m_req         (m_req),
      .m_addr        (m_addr),
      .m_wdata       (m_wdata),
      .m_ack         (m_ack),
      .core_rst_b    (core_rst_b),
      .busy          (busy),
      .err           (err),
      .words_written (words_written)
   );

   // Slave: latch the request on its first cycle, flag any change while pending, ack after the delay
   always @(negedge clk) begin
      if (!m_req) begin
         m_ack = 1'b0;
         hold  = 0;
      end else begin
         if (hold == 0) begin
            h_addr = m_addr;
            h_data = m_wdata;
         end else if (m_addr !== h_addr || m_wdata !== h_data || rx_ready !== 1'b0) begin
            unstable = 1'b1;
         end
         hold  = hold + 1;
         m_ack = (hold > ack_delay);
      end
   end

   // Record each completed write with the number of cycles the request was held
   always @(posedge clk) begin
      if (m_req && m_ack && wr_n < 8) begin
         wr_addr[wr_n] = m_addr;
         wr_data[wr_n] = m_wdata;
         wr_hold[wr_n] = hold;
         wr_n = wr_n + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present a byte and return just after the edge that accepts it; rx_valid stays high
   task automatic send_byte(input logic [7:0] b);
      int t;
      rx_data  = b;
      rx_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!rx_ready && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("byte_accept_wait", 32'(t < 3000), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic send_seq(input logic [7:0] q[$]);
      foreach (q[i]) send_byte(q[i]);
      rx_valid = 1'b0;
   endtask

   logic [7:0] good2[$] = '{8'hB0, 8'h00, 8'h00, 8'h40, 8'h00, 8'h02, 8'h00,
                            8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'hFA};
   logic [7:0] bad2_tail[$] = '{8'h00, 8'h00, 8'h40, 8'h00, 8'h02, 8'h00,
                            8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'hFB};
   logic [7:0] unal[$]   = '{8'hB0, 8'h02, 8'h00, 8'h40, 8'h00};
   logic [7:0] stall[$]  = '{8'hB0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE};
   logic [7:0] one_tail[$] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00,
                            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h3A};
   logic [7:0] one_nocs[$] = '{8'hB0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00,
                            8'hEF, 8'hBE, 8'hAD, 8'hDE};

   initial begin
      int t;
      // Reset state
      cycles(3);
      check("rst_rx_ready", 32'(rx_ready), 32'd1);
      check("rst_m_req",    32'(m_req), 32'd0);
      check("rst_m_addr",   m_addr, 32'd0);
      check("rst_m_wdata",  m_wdata, 32'd0);
      check("rst_core_rst", 32'(core_rst_b), 32'd0);
      check("rst_busy",     32'(busy), 32'd0);
      check("rst_err",      32'(err), 32'd0);
      check("rst_words",    32'(words_written), 32'd0);
      rst_b = 1'b1;
      cycles(2);

      // Good two-word frame, immediate ack
      wr_n = 0;
      ack_delay = 0;
      send_seq(good2);
      check("t1_core_rst_b_accept_cycle", 32'(core_rst_b), 32'd0);
      cycles(1);
      check("t1_core_rst_b_rise", 32'(core_rst_b), 32'd1);
      check("t1_err",   32'(err), 32'd0);
      check("t1_busy",  32'(busy), 32'd0);
      check("t1_words", 32'(words_written), 32'd2);
      check("t1_wr_n",  32'(wr_n), 32'd2);
      check("t1_addr0", wr_addr[0], 32'h0040_0000);
      check("t1_data0", wr_data[0], 32'h1122_3344);
      check("t1_addr1", wr_addr[1], 32'h0040_0004);
      check("t1_data1", wr_data[1], 32'hAABB_CCDD);

      // Reload re-holds the core; bad checksum leaves writes done but flags error
      wr_n = 0;
      send_byte(8'hB0);
      rx_valid = 1'b0;
      check("t2_core_rst_b_reheld", 32'(core_rst_b), 32'd0);
      check("t2_busy_in_frame", 32'(busy), 32'd1);
      send_seq(bad2_tail);
      cycles(2);
      check("t2_err",      32'(err), 32'd1);
      check("t2_core_rst", 32'(core_rst_b), 32'd0);
      check("t2_busy",     32'(busy), 32'd0);
      check("t2_wr_n",     32'(wr_n), 32'd2);

      // Slow slave: request held stable for six cycles, bytes wait without loss
      wr_n = 0;
      unstable = 1'b0;
      ack_delay = 5;
      send_seq(good2);
      cycles(2);
      check("t3_wr_n",     32'(wr_n), 32'd2);
      check("t3_hold0",    32'(wr_hold[0]), 32'd6);
      check("t3_hold1",    32'(wr_hold[1]), 32'd6);
      check("t3_stable",   32'(unstable), 32'd0);
      check("t3_data1",    wr_data[1], 32'hAABB_CCDD);
      check("t3_core_rst", 32'(core_rst_b), 32'd1);
      check("t3_err",      32'(err), 32'd0);
      ack_delay = 0;

      // Unaligned start address aborts after the fourth address byte
      wr_n = 0;
      send_seq(unal);
      cycles(2);
      check("t4_err",  32'(err), 32'd1);
      check("t4_wr_n", 32'(wr_n), 32'd0);
      check("t4_busy", 32'(busy), 32'd0);

      // Stall mid-data until the idle timer expires, then recover with a good frame
      wr_n = 0;
      send_seq(stall);
      check("t5_busy_stalled", 32'(busy), 32'd1);
      cycles(TMO + 10);
      check("t5_tmo_err",  32'(err), 32'd1);
      check("t5_tmo_busy", 32'(busy), 32'd0);
      check("t5_tmo_wr_n", 32'(wr_n), 32'd0);
      send_byte(8'hB0);
      rx_valid = 1'b0;
      check("t5_err_cleared", 32'(err), 32'd0);
      send_seq(one_tail);
      cycles(1);
      check("t5_core_rst", 32'(core_rst_b), 32'd1);
      check("t5_err",      32'(err), 32'd0);
      check("t5_words",    32'(words_written), 32'd1);
      check("t5_wr_n",     32'(wr_n), 32'd1);
      check("t5_addr0",    wr_addr[0], 32'h0000_0100);
      check("t5_data0",    wr_data[0], 32'hDEAD_BEEF);

      // Reset asserted while a write is pending
      ack_delay = 1000;
      send_seq(one_nocs);
      t = 0;
      @(negedge clk);
      while (!m_req && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("t6_m_req_pending", 32'(m_req), 32'd1);
      check("t6_core_held",     32'(core_rst_b), 32'd0);
      #2 rst_b = 1'b0;
      #1;
      check("t6_m_req_async",   32'(m_req), 32'd0);
      check("t6_rx_ready",      32'(rx_ready), 32'd1);
      check("t6_m_addr",        m_addr, 32'd0);
      check("t6_m_wdata",       m_wdata, 32'd0);
      check("t6_core_rst",      32'(core_rst_b), 32'd0);
      check("t6_busy",          32'(busy), 32'd0);
      check("t6_err",           32'(err), 32'd0);
      check("t6_words",         32'(words_written), 32'd0);
      cycles(1);
      rst_b = 1'b1;
      ack_delay = 0;
      cycles(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
